pipeline_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. It turns three events into per-stage hold and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers:
- `load_use` from the forwarding unit,
- taken branches/jumps resolved in EX,
- multi-cycle bus accesses issued by the MEM stage.

It also sequences each memory suspend through a small FSM, pulses `suspend_finish` back to the forwarding unit, enforces a bus timeout and keeps a stall-cycle performance counter.

---
 rtl/pipeline_ctrl_if.sv | 30 +++
 rtl/pipeline_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs, bus handshake and stall/flush controls of pipeline_ctrl
interface pipeline_ctrl_if;
    logic        load_use;
    logic        ex_jump;
    logic        mem_req;
    logic        mem_ack;
    logic        bus_req;
    logic        pc_stall;
    logic        ifid_stall;
    logic        idex_stall;
    logic        exmem_stall;
    logic        ifid_flush;
    logic        idex_flush;
    logic        memwb_flush;
    logic        suspend_finish;
    logic        bus_timeout;
    logic [31:0] stall_cnt;

    modport master (
        output load_use, ex_jump, mem_req, mem_ack,
        input  bus_req, pc_stall, ifid_stall, idex_stall, exmem_stall,
        input  ifid_flush, idex_flush, memwb_flush, suspend_finish, bus_timeout, stall_cnt
    );

    modport slave (
        input  load_use, ex_jump, mem_req, mem_ack,
        output bus_req, pc_stall, ifid_stall, idex_stall, exmem_stall,
        output ifid_flush, idex_flush, memwb_flush, suspend_finish, bus_timeout, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller with memory-suspend FSM
module pipeline_ctrl #(
    parameter int TIMEOUT = 256
) (
    input logic            cpu_clk,
    input logic            cpu_rst,
    pipeline_ctrl_if.slave ctl
);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   stall_cnt_q;
    logic          timeout_flag;
    logic          timeout_hit;
    logic          frozen;

    logic bus_req;
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;

    always_comb begin
        state_nxt   = state;
        frozen      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            RUN: begin
                if (ctl.mem_req) begin
                    frozen    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                frozen = 1'b1;
                // An ack on the last allowed cycle wins over the timeout.
                if (ctl.mem_ack) begin
                    state_nxt = DONE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    state_nxt   = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        bus_req     = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (!cpu_rst) begin
            bus_req = frozen;
            // Hazards are left pending while frozen; the held stages re-present them on release.
            if (frozen) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                memwb_flush = 1'b1;
            end else if (ctl.ex_jump) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (ctl.load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state != WAIT) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end
            if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign ctl.bus_req        = bus_req;
    assign ctl.pc_stall       = pc_stall;
    assign ctl.ifid_stall     = ifid_stall;
    assign ctl.idex_stall     = idex_stall;
    assign ctl.exmem_stall    = exmem_stall;
    assign ctl.ifid_flush     = ifid_flush;
    assign ctl.idex_flush     = idex_flush;
    assign ctl.memwb_flush    = memwb_flush;
    assign ctl.suspend_finish = !cpu_rst && (state == DONE);
    assign ctl.bus_timeout    = !cpu_rst && timeout_flag;
    assign ctl.stall_cnt      = cpu_rst ? 32'd0 : stall_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;
    localparam int TO = 4;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;

    pipeline_ctrl_if sif ();

    pipeline_ctrl #(.TIMEOUT(TO)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .ctl     (sif)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: whether an access is outstanding, how many wait cycles it has used,
    // whether the finish cycle is due, sticky timeout and the stall total.
    bit     m_waiting = 1'b0;
    bit     m_done    = 1'b0;
    bit     m_to      = 1'b0;
    int     m_waited  = 0;
    longint m_cnt     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] outs();
        return {sif.bus_req, sif.pc_stall, sif.ifid_stall, sif.idex_stall, sif.exmem_stall,
                sif.ifid_flush, sif.idex_flush, sif.memwb_flush, sif.suspend_finish, sif.bus_timeout};
    endfunction

    always @(negedge cpu_clk) begin
        logic [9:0]  e;
        logic [31:0] ecnt;
        bit          frz;
        e    = '0;
        ecnt = '0;
        frz  = 1'b0;
        if (!cpu_rst) begin
            frz = m_waiting || (!m_done && sif.mem_req);
            if (frz) begin
                e = 10'b1111100100;
            end else if (sif.ex_jump) begin
                e = 10'b0000011000;
            end else if (sif.load_use) begin
                e = 10'b0110001000;
            end
            e[1] = m_done;
            e[0] = m_to;
            ecnt = (m_cnt > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_cnt[31:0];
        end
        chk("model_ctl", outs(), e);
        chk("model_cnt", sif.stall_cnt, ecnt);

        if (cpu_rst) begin
            m_waiting = 1'b0;
            m_done    = 1'b0;
            m_to      = 1'b0;
            m_waited  = 0;
            m_cnt     = 0;
        end else begin
            if (e[8]) m_cnt++;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_waiting) begin
                if (sif.mem_ack) begin
                    m_waiting = 1'b0;
                    m_done    = 1'b1;
                end else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_waiting = 1'b0;
                        m_done    = 1'b1;
                        m_to      = 1'b1;
                    end
                end
            end else if (sif.mem_req) begin
                m_waiting = 1'b1;
                m_waited  = 0;
            end
        end
    end

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    // Holds mem_req from the current cycle until the finish pulse; ack_at is the
    // WAIT-cycle index carrying mem_ack (-1 = never). Returns in the DONE cycle.
    task automatic access(input int ack_at, output int frz, output int breq,
                          output int flsh, output bit fin);
        frz  = 0;
        breq = 0;
        flsh = 0;
        fin  = 1'b0;
        for (int c = 0; c < TO + 6; c++) begin
            if (c > 0) step();
            sif.mem_req = 1'b1;
            sif.mem_ack = (ack_at >= 0) && (c == ack_at + 1);
            #2;
            if (sif.suspend_finish) begin
                fin = 1'b1;
                sif.mem_ack = 1'b0;
                break;
            end
            frz  += int'(sif.pc_stall);
            breq += int'(sif.bus_req);
            flsh += int'(sif.ifid_flush | sif.idex_flush);
        end
    endtask

    initial begin
        int frz, breq, flsh;
        bit fin;

        sif.load_use = 1'b0;
        sif.ex_jump  = 1'b0;
        sif.mem_req  = 1'b0;
        sif.mem_ack  = 1'b0;
        cpu_rst      = 1'b1;
        step();
        sif.mem_req = 1'b1;
        sif.load_use = 1'b1;
        #2;
        chk("rst_outs", outs(), 10'b0);
        chk("rst_cnt", sif.stall_cnt, 32'd0);
        step();
        sif.mem_req  = 1'b0;
        sif.load_use = 1'b0;
        cpu_rst      = 1'b0;

        step();
        sif.load_use = 1'b1;
        #2;
        chk("lu_ctl", outs(), 10'b0110001000);
        step();
        sif.ex_jump = 1'b1;
        #2;
        chk("lu_cnt", sif.stall_cnt, 32'd1);
        chk("jump_ctl", outs(), 10'b0000011000);
        step();
        sif.load_use = 1'b0;
        #2;
        chk("jump_cnt", sif.stall_cnt, 32'd1);

        // Memory suspend with ack on the 3rd WAIT cycle, jump pending throughout.
        step();
        access(2, frz, breq, flsh, fin);
        chk("sus_fin", fin, 1'b1);
        chk("sus_freeze", frz, 4);
        chk("sus_busreq", breq, 4);
        chk("sus_noflush", flsh, 0);
        chk("sus_done", outs(), 10'b0000011010);
        step();
        sif.mem_req = 1'b0;
        sif.ex_jump = 1'b0;
        #2;
        chk("sus_cnt", sif.stall_cnt, 32'd5);
        chk("sus_run", outs(), 10'b0);

        // Timeout, then a back-to-back access straight after DONE.
        step();
        access(-1, frz, breq, flsh, fin);
        chk("to_fin", fin, 1'b1);
        chk("to_freeze", frz, TO + 1);
        chk("to_done", outs(), 10'b0000000011);
        step();
        access(0, frz, breq, flsh, fin);
        chk("b2b_fin", fin, 1'b1);
        chk("b2b_freeze", frz, 2);
        chk("b2b_done", outs(), 10'b0000000011);
        step();
        sif.mem_req = 1'b0;
        #2;
        chk("b2b_cnt", sif.stall_cnt, 32'd12);
        chk("to_sticky", sif.bus_timeout, 1'b1);

        // Reset in the middle of WAIT.
        step();
        sif.mem_req = 1'b1;
        step();
        step();
        cpu_rst = 1'b1;
        #2;
        chk("rw_outs", outs(), 10'b0);
        chk("rw_cnt", sif.stall_cnt, 32'd0);
        step();
        cpu_rst     = 1'b0;
        sif.mem_req = 1'b0;
        #2;
        chk("rw_after", outs(), 10'b0);

        // Ack on the last allowed WAIT cycle counts as a normal completion.
        step();
        access(TO - 1, frz, breq, flsh, fin);
        chk("edge_fin", fin, 1'b1);
        chk("edge_freeze", frz, TO + 1);
        chk("edge_done", outs(), 10'b0000000010);
        step();
        sif.mem_req = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            step();
            cpu_rst      = ($urandom_range(0, 199) == 0);
            sif.load_use = ($urandom_range(0, 2) == 0);
            sif.ex_jump  = ($urandom_range(0, 3) == 0);
            sif.mem_req  = ($urandom_range(0, 3) == 0);
            sif.mem_ack  = ($urandom_range(0, 5) == 0);
        end
        step();
        cpu_rst = 1'b0;
        sif.mem_req = 1'b0;
        sif.mem_ack = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
